// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external-SRAM arbiter.
package sram_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Watchdog counter width
    localparam int WDOG_W = 8;

    // Requester operation encoding (req_we bit)
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin picker: first requester above last_grant, wrapping.
module sram_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   win_o,
    output logic               any_o
);

    // Search last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first hit wins
    always_comb begin
        logic found;
        found = 1'b0;
        win_o = last_grant_i;
        for (int i = 1; i <= NUM_REQ; i++) begin
            automatic int         cand = (int'(last_grant_i) + i) % NUM_REQ;
            automatic logic [IDX_W-1:0] idx = IDX_W'(cand);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win_o = idx;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one SRAM controller.
// Handshake: a requester holds req and its command stable until its one-cycle
// ack; the controller gets a one-cycle read_en/wr_en strobe and answers with a
// one-cycle read_valid/wr_valid strobe; a watchdog aborts a silent controller.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           ack_err,
    output logic [DATA_W-1:0]              rdata,
    output logic                           busy,
    output logic                           read_en,
    output logic                           wr_en,
    output logic [ADDR_W-1:0]              address,
    output logic [DATA_W-1:0]              wr_data,
    input  logic                           read_valid,
    input  logic                           wr_valid,
    input  logic [DATA_W-1:0]              read_data,
    output arb_state_t                     dbg_state_o
);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                ack_err_q, ack_err_d;
    logic                busy_q, busy_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;

    logic [IDX_W-1:0]    pick_win;
    logic                pick_any;

    sram_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (last_q),
        .win_o        (pick_win),
        .any_o        (pick_any)
    );

    // Next-state logic; every output register is loaded with its value for the next state
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wdog_d    = wdog_q;
        rdata_d   = rdata_q;
        ack_d     = '0;
        ack_err_d = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    win_d   = pick_win;
                    we_d    = req_we[pick_win];
                    addr_d  = req_addr[pick_win];
                    wdata_d = req_wdata[pick_win];
                    rd_en_d = (req_we[pick_win] == OP_READ);
                    wr_en_d = (req_we[pick_win] == OP_WRITE);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                last_d  = win_q;
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (we_q == OP_READ && read_valid) begin
                    rdata_d       = read_data;
                    ack_d[win_q]  = 1'b1;
                    state_d       = DONE;
                end else if (we_q == OP_WRITE && wr_valid) begin
                    ack_d[win_q]  = 1'b1;
                    state_d       = DONE;
                end else begin
                    wdog_d = (wdog_q == {WDOG_W{1'b1}}) ? wdog_q : wdog_q + 1'b1;
                    if (wdog_d == WDOG_W'(TIMEOUT_CYCLES)) begin
                        rdata_d      = '0;
                        ack_d[win_q] = 1'b1;
                        ack_err_d    = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, command latches and output registers; reset aborts any transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_q     <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wdog_q    <= '0;
            rdata_q   <= '0;
            ack_q     <= '0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wdog_q    <= wdog_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign ack         = ack_q;
    assign ack_err     = ack_err_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign read_en     = rd_en_q;
    assign wr_en       = wr_en_q;
    assign address     = addr_q;
    assign wr_data     = wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic
// against a round-robin reference model.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int TMO     = 10;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic [NUM_REQ-1:0]             req = '0;
    logic [NUM_REQ-1:0]             req_we = '0;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]             ack;
    logic                           ack_err;
    logic [DATA_W-1:0]              rdata;
    logic                           busy, read_en, wr_en;
    logic [ADDR_W-1:0]              address;
    logic [DATA_W-1:0]              wr_data;
    logic                           read_valid = 1'b0;
    logic                           wr_valid = 1'b0;
    logic [DATA_W-1:0]              read_data = '0;
    arb_state_t                     dbg_state;

    int total = 0;
    int bad   = 0;
    int m_last = NUM_REQ - 1;   // reference model: last granted requester
    logic [31:0] exp_q[$];      // expected grant order for the contention run

    sram_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .ack_err(ack_err), .rdata(rdata),
        .busy(busy), .read_en(read_en), .wr_en(wr_en), .address(address),
        .wr_data(wr_data), .read_valid(read_valid), .wr_valid(wr_valid),
        .read_data(read_data), .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first set bit after the last grant, wrapping around
    function automatic int model_pick(input logic [NUM_REQ-1:0] m);
        for (int i = 1; i <= NUM_REQ; i++) begin
            automatic int c = (m_last + i) % NUM_REQ;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // One transaction, entered at a negedge in IDLE with requests already driven.
    // k: WAIT cycle in which the controller strobes; to: controller stays silent;
    // wrong_w: WAIT cycle carrying an opposite-type strobe (0 = none).
    task automatic run_txn(input int k, input bit to, input int wrong_w, output int win);
        int cyc, w, exp_w;
        bit we, acked;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd, rd;
        win = model_pick(req);
        if (win < 0) win = 0;
        m_last = win;
        we = req_we[win]; a = req_addr[win]; wd = req_wdata[win];
        rd = DATA_W'($urandom);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(read_en || wr_en) && cyc < 20);
        chk("issue_latency", cyc, 1);
        chk("read_en", 32'(read_en), 32'(!we));
        chk("wr_en", 32'(wr_en), 32'(we));
        chk("address", 32'(address), 32'(a));
        if (we) chk("wr_data", 32'(wr_data), 32'(wd));
        chk("busy_issue", 32'(busy), 1);
        w = 0; acked = 0;
        while (!acked && w < 60) begin
            @(negedge clk);
            w++;
            read_valid = 1'b0; wr_valid = 1'b0;
            read_data  = DATA_W'($urandom);
            if (ack != '0) begin
                acked = 1;
            end else begin
                chk("strobe_once", 32'({read_en, wr_en}), 0);
                chk("state_wait", 32'(dbg_state), 32'(WAIT));
                if (!to && w == k) begin
                    if (we) wr_valid = 1'b1;
                    else begin read_valid = 1'b1; read_data = rd; end
                end
                if (w == wrong_w) begin
                    if (we) read_valid = 1'b1;
                    else wr_valid = 1'b1;
                end
            end
        end
        exp_w = to ? TMO + 1 : k + 1;
        chk("ack_latency", w, exp_w);
        chk("ack_vec", 32'(ack), 32'(1 << win));
        chk("ack_err", 32'(ack_err), 32'(to));
        if (!we || to) chk("rdata", 32'(rdata), to ? 32'd0 : 32'(rd));
        chk("busy_done", 32'(busy), 1);
        @(negedge clk);
        chk("ack_pulse", 32'(ack), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    task automatic set_cmd(input int r, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req[r] = 1'b1; req_we[r] = we; req_addr[r] = a; req_wdata[r] = d;
    endtask

    initial begin
        int win, k, ww;
        bit to;
        // Reset
        @(negedge clk); @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_strobes", 32'({read_en, wr_en}), 0);
        chk("rst_rdata", 32'(rdata), 0);
        rst = 1'b0;

        // Single read
        set_cmd(0, 1'b0, 18'h00010, 16'h0);
        run_txn(1, 0, 0, win);
        req = '0;
        // Single write to the top address
        set_cmd(1, 1'b1, 18'h3FFFF, 16'h1234);
        run_txn(2, 0, 0, win);
        req = '0;

        // Contention after a fresh reset: grants must alternate 0,1,0,1,0,1
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; m_last = NUM_REQ - 1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i % 2));
        set_cmd(0, 1'b0, 18'h00100, 16'h0);
        set_cmd(1, 1'b1, 18'h00200, 16'h5A5A);
        for (int i = 0; i < 6; i++) begin
            run_txn($urandom_range(1, 3), 0, 0, win);
            chk("contention_order", 32'(win), exp_q.pop_front());
        end
        req = '0;

        // Timeout, then a normal request
        set_cmd(0, 1'b0, 18'h01234, 16'h0);
        run_txn(0, 1, 0, win);
        req = '0;
        set_cmd(1, 1'b0, 18'h02345, 16'h0);
        run_txn(1, 0, 0, win);
        req = '0;

        // Wrong strobe during a read is ignored
        set_cmd(0, 1'b0, 18'h0ABCD, 16'h0);
        run_txn(3, 0, 1, win);
        req = '0;

        // Strobes in IDLE are ignored
        read_valid = 1'b1; wr_valid = 1'b1;
        @(negedge clk);
        read_valid = 1'b0; wr_valid = 1'b0;
        chk("idle_strobe_busy", 32'(busy), 0);
        chk("idle_strobe_ack", 32'(ack), 0);
        @(negedge clk);
        chk("idle_strobe_state", 32'(dbg_state), 32'(IDLE));

        // Reset mid-WAIT aborts without ack; requester 0 wins first afterwards
        set_cmd(1, 1'b0, 18'h00777, 16'h0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_strobes", 32'({read_en, wr_en}), 0);
        chk("arst_ack", 32'(ack), 0);
        @(negedge clk);
        chk("arst_hold_ack", 32'(ack), 0);
        rst = 1'b0; m_last = NUM_REQ - 1;
        set_cmd(0, 1'b1, 18'h00042, 16'hC0DE);
        run_txn(1, 0, 0, win);
        chk("post_reset_winner", 32'(win), 0);
        req = '0;

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < NUM_REQ; r++)
                if (!req[r] && $urandom_range(0, 1) == 1)
                    set_cmd(r, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
            if (req == '0)
                set_cmd($urandom_range(0, NUM_REQ - 1), 1'($urandom_range(0, 1)),
                        ADDR_W'($urandom), DATA_W'($urandom));
            to = ($urandom_range(0, 7) == 0);
            k  = $urandom_range(1, 4);
            ww = (!to && k > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, k - 1) : 0;
            run_txn(k, to, ww, win);
            if ($urandom_range(0, 1) == 1)
                set_cmd(win, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
            else
                req[win] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
